config_shift_ctrl: RTL
======================

Name: config_shift_ctrl

Overview:
- Sequences the overlay configuration scan chain (SE/SIN/SOUT) from byte commands received over the UART handshake.
- Streams the bitstream into the chain LSB-first, one bit per enable cycle.
- Captures the displaced chain contents and returns them as readback bytes.
- Holds the user clock/reset domain quiescent while loading; sits between UART and OVERLAY, replacing the ad-hoc decoder.

Parameters:
- LEN_W, 16, width of the bit-length field; max load length is 2^LEN_W-1 bits.
- TIMEOUT, 10000000, SCLK cycles allowed between received bytes mid-command before abort.
- CMD_LOAD, 8'h4C, load-command opcode ('L').

Ports:
- SCLK  input  1  system clock
- SYSRST  input  1  synchronous active-low reset
- RX_VALID  input  1  one-cycle strobe: RX_DATA holds a received byte
- RX_DATA  input  8  received byte
- TX_READY  input  1  UART can accept a byte this cycle
- TX_VALID  output  1  one-cycle strobe: send TX_DATA (only when TX_READY=1)
- TX_DATA  output  8  byte to transmit
- SHIFT_HEAD  output  1  bit presented to chain input SIN
- SHIFT_TAIL  input  1  chain output SOUT
- SHIFT_ENABLE  output  1  chain shift enable SE; chain advances one bit at each SCLK edge while high
- USER_HOLD  output  1  high while not IDLE; top level gates UCLK and forces URST
- DONE  output  1  one-cycle pulse when a load completes with ack 'K'

Behaviour:
- Reset (SYSRST=0 at SCLK edge, wins over all inputs):
  - State IDLE; all outputs 0; counters, timeout and readback shift register cleared.
  - A reset mid-load abandons it silently; no ack is sent and the chain keeps its partial contents.
- States: IDLE, LEN_LO, LEN_HI, WAIT_DATA, SHIFT, SEND_RB, SEND_ACK.
- IDLE:
  - RX byte == CMD_LOAD -> LEN_LO.
  - Any other byte -> SEND_ACK with code 8'h3F ('?').
- LEN_LO / LEN_HI: capture the length little-endian; bits above LEN_W are ignored.
  - Length 0 -> SEND_ACK 'K'.
  - Otherwise -> WAIT_DATA with the remaining-bit counter N = length.
- WAIT_DATA: on RX_VALID, latch the byte -> SHIFT with bit index 0.
- SHIFT: one bit per cycle, 8 bits per byte.
  - SHIFT_ENABLE=1 and SHIFT_HEAD=byte[idx] in the same cycle.
  - SHIFT_TAIL is sampled into the readback register (LSB-first) in that cycle.
  - N decrements per bit.
- Leaving SHIFT, checked in this order:
  - After 8 bits, or when N reaches 0, -> SEND_RB.
  - Bits of the final byte past N are not shifted.
  - The final readback byte is right-justified, with upper bits 0.
- SEND_RB: SHIFT_ENABLE=0; wait for TX_READY, then TX_VALID for exactly one cycle carrying the readback byte.
  - If N>0 -> WAIT_DATA; else -> SEND_ACK 'K'.
  - The chain never shifts while readback is pending, which back-pressures via UART TX.
- SEND_ACK: wait for TX_READY, then one-cycle TX_VALID with the code.
  - DONE pulses in the same cycle only for 'K'.
  - -> IDLE.
- RX bytes arriving in SHIFT, SEND_RB or SEND_ACK are dropped. The host must wait for each readback byte before sending the next data byte.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI and WAIT_DATA; it clears on every RX_VALID and on each state entry.
  - Reaching TIMEOUT -> SEND_ACK with 8'h54 ('T').
- Latency:
  - Data byte RX_VALID -> first SE cycle: 1 cycle.
  - Last SE cycle -> readback TX_VALID: at least 1 cycle.
- USER_HOLD = (state != IDLE), registered.

Optional Feature:
- Macro CONFIG_CHECKSUM_EN.
- When defined:
  - After the final readback byte, state CHECKSUM waits (under timeout) for one extra RX byte.
  - That byte is compared with the XOR of all data bytes received in this command.
  - Match -> ack 'K'; mismatch -> ack 8'h45 ('E'), DONE not pulsed.
  - The chain contents are not restored on mismatch.
- When undefined: no CHECKSUM state; ack immediately follows the last readback byte.

Test Plan:
- Load length 16, data 8'hA5, 8'h3C, TX_READY=1:
  - SE high for exactly 16 cycles in two 8-cycle bursts.
  - SHIFT_HEAD sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Two readback bytes, then 'K' with DONE.
- Prepare a 16-bit loopback chain holding 16'h1234, then load 16 bits:
  - Readback bytes are 8'h34 then 8'h12.
- Load length 5 with byte 8'hFF:
  - 5 SE cycles.
  - Readback upper 3 bits are 0.
  - 'K' follows.
- Hold TX_READY=0 for 100 cycles during SEND_RB:
  - SE stays 0 and TX_VALID stays 0.
  - The byte is sent the cycle TX_READY rises, then normal flow resumes.
- Send 'L' and one length byte, then silence for TIMEOUT cycles:
  - 'T' is transmitted and the controller returns to IDLE.
  - Byte 8'h00 then yields '?'.
- SYSRST low for one cycle mid-SHIFT:
  - All outputs 0 the next cycle and no ack is sent.
  - A subsequent full load succeeds.
  - With CONFIG_CHECKSUM_EN, a wrong checksum byte returns 'E' with no DONE pulse.

Source files
------------

// File: rtl/config_shift_ctrl_if.sv
// Interface bundling the UART byte handshake and the overlay scan-chain pins
// of config_shift_ctrl.
//   master : UART + overlay side (drives RX_*, TX_READY, SHIFT_TAIL)
//   slave  : the controller     (drives TX_*, SHIFT_HEAD/ENABLE, USER_HOLD, DONE)
// Signals:
//   RX_VALID/RX_DATA   received-byte strobe and byte
//   TX_READY           UART can accept a byte this cycle
//   TX_VALID/TX_DATA   transmit strobe and byte
//   SHIFT_HEAD         chain input SIN
//   SHIFT_TAIL         chain output SOUT
//   SHIFT_ENABLE       chain shift enable SE
//   USER_HOLD          user domain held quiescent
//   DONE               load completed with ack 'K'
interface config_shift_ctrl_if;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       TX_READY;
    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic       SHIFT_HEAD;
    logic       SHIFT_TAIL;
    logic       SHIFT_ENABLE;
    logic       USER_HOLD;
    logic       DONE;

    modport master (
        output RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
        input  TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, USER_HOLD, DONE
    );

    modport slave (
        input  RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
        output TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, USER_HOLD, DONE
    );
endinterface

// File: rtl/config_shift_ctrl.sv
// Overlay configuration scan-chain sequencer.
// Decodes byte commands from the UART: 'L', length (little-endian), then data
// bytes. Each data byte is streamed LSB-first into the chain, one bit per
// SHIFT_ENABLE cycle; the displaced chain bits are returned as a readback
// byte before the next data byte is accepted. A final ack byte ends every
// command ('K' ok, '?' unknown opcode, 'T' inter-byte timeout).
// Optional feature (macro CONFIG_CHECKSUM_EN): after the last readback byte an
// extra byte is received and compared with the XOR of all data bytes; mismatch
// acks 'E' without DONE.
// Ports:
//   SCLK    system clock
//   SYSRST  synchronous active-low reset
//   bus     config_shift_ctrl_if.slave (UART handshake + chain pins)
module config_shift_ctrl #(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned TIMEOUT  = 10000000,
    parameter logic [7:0]  CMD_LOAD = 8'h4C
) (
    input logic             SCLK,
    input logic             SYSRST,
    config_shift_ctrl_if.slave bus
);

    localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  AckOk  = 8'h4B;  // 'K'
    localparam logic [7:0]  AckBad = 8'h3F;  // '?'
    localparam logic [7:0]  AckTmo = 8'h54;  // 'T'
`ifdef CONFIG_CHECKSUM_EN
    localparam logic [7:0]  AckErr = 8'h45;  // 'E'
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StWaitData,
        StShift,
        StSendRb,
        StSendAck
`ifdef CONFIG_CHECKSUM_EN
        , StChecksum
`endif
    } state_e;

    state_e            state_q;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  n_q;       // bits still to shift
    logic [7:0]        data_q;
    logic [2:0]        idx_q;
    logic [7:0]        rb_q;
    logic [TmoW-1:0]   tmo_q;
    logic [7:0]        code_q;
    logic              se_q;
    logic              head_q;
    logic              hold_q;
`ifdef CONFIG_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic [15:0]       len_raw;
    logic [LEN_W-1:0]  len_w;
    logic              tmo_hit;

    assign len_raw = {bus.RX_DATA, len_lo_q};
    assign len_w   = LEN_W'(len_raw);
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

    always_ff @(posedge SCLK) begin
        if (!SYSRST) begin
            state_q  <= StIdle;
            len_lo_q <= '0;
            n_q      <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            rb_q     <= '0;
            tmo_q    <= '0;
            code_q   <= '0;
            se_q     <= 1'b0;
            head_q   <= 1'b0;
            hold_q   <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            // Timeout counter only survives while parked in a receive state
            // with no byte arriving; any other path clears it.
            tmo_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.RX_VALID) begin
                        hold_q <= 1'b1;
                        if (bus.RX_DATA == CMD_LOAD) begin
                            state_q <= StLenLo;
`ifdef CONFIG_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end else begin
                            state_q <= StSendAck;
                            code_q  <= AckBad;
                        end
                    end
                end
                StLenLo: begin
                    if (bus.RX_VALID) begin
                        len_lo_q <= bus.RX_DATA;
                        state_q  <= StLenHi;
                    end else if (tmo_hit) begin
                        state_q <= StSendAck;
                        code_q  <= AckTmo;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StLenHi: begin
                    if (bus.RX_VALID) begin
                        n_q <= len_w;
                        if (len_w == '0) begin
                            state_q <= StSendAck;
                            code_q  <= AckOk;
                        end else begin
                            state_q <= StWaitData;
                        end
                    end else if (tmo_hit) begin
                        state_q <= StSendAck;
                        code_q  <= AckTmo;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StWaitData: begin
                    if (bus.RX_VALID) begin
                        data_q  <= bus.RX_DATA;
                        idx_q   <= '0;
                        rb_q    <= '0;  // keeps a short final byte right-justified
                        se_q    <= 1'b1;
                        head_q  <= bus.RX_DATA[0];
                        state_q <= StShift;
`ifdef CONFIG_CHECKSUM_EN
                        csum_q  <= csum_q ^ bus.RX_DATA;
`endif
                    end else if (tmo_hit) begin
                        state_q <= StSendAck;
                        code_q  <= AckTmo;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StShift: begin
                    rb_q[idx_q] <= bus.SHIFT_TAIL;
                    n_q         <= n_q - LEN_W'(1);
                    if (idx_q == 3'd7 || n_q == LEN_W'(1)) begin
                        se_q    <= 1'b0;
                        head_q  <= 1'b0;
                        state_q <= StSendRb;
                    end else begin
                        idx_q  <= idx_q + 3'd1;
                        head_q <= data_q[idx_q + 3'd1];
                    end
                end
                StSendRb: begin
                    if (bus.TX_READY) begin
                        if (n_q != '0) begin
                            state_q <= StWaitData;
                        end else begin
`ifdef CONFIG_CHECKSUM_EN
                            state_q <= StChecksum;
`else
                            state_q <= StSendAck;
                            code_q  <= AckOk;
`endif
                        end
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                StChecksum: begin
                    if (bus.RX_VALID) begin
                        state_q <= StSendAck;
                        code_q  <= (bus.RX_DATA == csum_q) ? AckOk : AckErr;
                    end else if (tmo_hit) begin
                        state_q <= StSendAck;
                        code_q  <= AckTmo;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
`endif
                StSendAck: begin
                    if (bus.TX_READY) begin
                        state_q <= StIdle;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    // TX_VALID follows TX_READY combinationally so a byte leaves in the very
    // cycle the UART becomes ready; the state it is gated by is registered.
    logic tx_rb, tx_ack;
    assign tx_rb  = (state_q == StSendRb);
    assign tx_ack = (state_q == StSendAck);

    assign bus.TX_VALID     = (tx_rb | tx_ack) & bus.TX_READY;
    assign bus.TX_DATA      = tx_rb ? rb_q : (tx_ack ? code_q : 8'h00);
    assign bus.DONE         = tx_ack & bus.TX_READY & (code_q == AckOk);
    assign bus.SHIFT_ENABLE = se_q;
    assign bus.SHIFT_HEAD   = head_q;
    assign bus.USER_HOLD    = hold_q;

endmodule
